// File: rtl/alu_result_fifo.sv
// rtl/alu_result_fifo.sv - in-order result FIFO between the ALU and writeback
//
// Captures each accepted ALU result {Z, FLAGS, DEST} into a DEPTH-entry FIFO
// and presents the head entry to writeback over a valid/ready handshake.
// Also accumulates sticky flags and a saturating upstream stall counter.
//
// Ports:
//   CLOCK, RESET         rising-edge clock, asynchronous active-high reset
//   IN_VALID/IN_READY    upstream handshake (IN_READY from registered state only)
//   Z, FLAGS, DEST       result word, {N,Z,C,V} flags, destination tag
//   OUT_VALID/OUT_READY  downstream handshake
//   OUT_DATA/FLAGS/DEST  head entry, zero while OUT_VALID is low
//   COUNT                current occupancy
//   STICKY_FLAGS         OR of flags of all entries accepted since last clear
//   CLEAR_STICKY         clear sticky flags (a same-cycle push still ORs in)
//   STALL_CNT            cycles with IN_VALID & !IN_READY, saturating

module alu_result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     CLOCK,
    input  logic                     RESET,
    input  logic                     IN_VALID,
    output logic                     IN_READY,
    input  logic [WIDTH-1:0]         Z,
    input  logic [3:0]               FLAGS,
    input  logic [4:0]               DEST,
    output logic                     OUT_VALID,
    input  logic                     OUT_READY,
    output logic [WIDTH-1:0]         OUT_DATA,
    output logic [3:0]               OUT_FLAGS,
    output logic [4:0]               OUT_DEST,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic [3:0]               STICKY_FLAGS,
    input  logic                     CLEAR_STICKY,
    output logic [15:0]              STALL_CNT
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = WIDTH + 9;
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [3:0]    sticky;
    logic [15:0]   stall_cnt;
    logic [EW-1:0] head;
    logic          push;
    logic          pop;

    // Ready depends only on registered occupancy, so a pop while full
    // cannot open the input in the same cycle.
    assign IN_READY  = (count < FULL_COUNT);
    assign OUT_VALID = (count != '0);
    assign push      = IN_VALID & IN_READY;
    assign pop       = OUT_VALID & OUT_READY;

    // Storage is not reset; stale contents are hidden by the output mask.
    always_ff @(posedge CLOCK) begin
        if (push) begin
            mem[wr_ptr] <= {Z, FLAGS, DEST};
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            sticky    <= 4'b0000;
            stall_cnt <= 16'h0000;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            // Clear takes effect first, then the pushed flags are ORed in.
            if (CLEAR_STICKY) begin
                sticky <= push ? FLAGS : 4'b0000;
            end else if (push) begin
                sticky <= sticky | FLAGS;
            end
            if (IN_VALID && !IN_READY && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

    assign head         = mem[rd_ptr];
    assign OUT_DATA     = OUT_VALID ? head[EW-1:9] : '0;
    assign OUT_FLAGS    = OUT_VALID ? head[8:5]    : 4'b0000;
    assign OUT_DEST     = OUT_VALID ? head[4:0]    : 5'b00000;
    assign COUNT        = count;
    assign STICKY_FLAGS = sticky;
    assign STALL_CNT    = stall_cnt;

endmodule

// File: tb/tb_alu_result_fifo.sv
// tb/tb_alu_result_fifo.sv - scoreboard testbench for alu_result_fifo

module tb_alu_result_fifo;

    localparam int DEPTH = 4;

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic        IN_VALID;
    logic        IN_READY;
    logic [31:0] Z;
    logic [3:0]  FLAGS;
    logic [4:0]  DEST;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [31:0] OUT_DATA;
    logic [3:0]  OUT_FLAGS;
    logic [4:0]  OUT_DEST;
    logic [2:0]  COUNT;
    logic [3:0]  STICKY_FLAGS;
    logic        CLEAR_STICKY;
    logic [15:0] STALL_CNT;

    alu_result_fifo #(.DEPTH(DEPTH), .WIDTH(32)) dut (
        .CLOCK(CLOCK), .RESET(RESET),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .Z(Z), .FLAGS(FLAGS), .DEST(DEST),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .OUT_DATA(OUT_DATA), .OUT_FLAGS(OUT_FLAGS), .OUT_DEST(OUT_DEST),
        .COUNT(COUNT), .STICKY_FLAGS(STICKY_FLAGS),
        .CLEAR_STICKY(CLEAR_STICKY), .STALL_CNT(STALL_CNT)
    );

    always #5 CLOCK = ~CLOCK;

    int checks = 0;
    int errors = 0;

    logic [40:0] sb_q[$];
    int          m_count;
    logic [3:0]  m_sticky;
    logic [15:0] m_stall;
    logic [31:0] last_pushed;

    task automatic model_clear();
        sb_q.delete();
        m_count  = 0;
        m_sticky = 4'b0000;
        m_stall  = 16'h0000;
    endtask

    // Drives one cycle (called at posedge+1), compares any popped entry against
    // the scoreboard and the ready flag against the model, then advances the model.
    task automatic drive_cycle(input logic iv, input logic [31:0] z, input logic [3:0] f,
                               input logic [4:0] d, input logic ordy, input logic clr);
        logic        exp_ready;
        logic        push;
        logic        pop;
        logic [40:0] exp_e;
        IN_VALID = iv; Z = z; FLAGS = f; DEST = d; OUT_READY = ordy; CLEAR_STICKY = clr;
        #1;
        exp_ready = (m_count < DEPTH);
        push = iv && exp_ready;
        pop  = ordy && (m_count != 0);
        checks++;
        if (IN_READY !== exp_ready) begin
            errors++;
            $display("FAIL in_ready: got %b expected %b", IN_READY, exp_ready);
        end
        if (pop) begin
            exp_e = sb_q[0];
            checks++;
            if (OUT_VALID !== 1'b1 || {OUT_DATA, OUT_FLAGS, OUT_DEST} !== exp_e) begin
                errors++;
                $display("FAIL pop_entry: got v=%b %h/%b/%0d expected %h/%b/%0d", OUT_VALID,
                         OUT_DATA, OUT_FLAGS, OUT_DEST, exp_e[40:9], exp_e[8:5], exp_e[4:0]);
            end
        end
        @(posedge CLOCK);
        #1;
        if (pop) void'(sb_q.pop_front());
        if (push) begin
            sb_q.push_back({z, f, d});
            last_pushed = z;
        end
        m_count = m_count + (push ? 1 : 0) - (pop ? 1 : 0);
        m_sticky = clr ? (push ? f : 4'b0000) : (m_sticky | (push ? f : 4'b0000));
        if (iv && !exp_ready && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
    endtask

    task automatic idle();
        drive_cycle(1'b0, 32'h0, 4'h0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        RESET = 1'b1; IN_VALID = 0; Z = 0; FLAGS = 0; DEST = 0; OUT_READY = 0; CLEAR_STICKY = 0;
        repeat (2) @(posedge CLOCK);
        #1 RESET = 1'b0;
        model_clear();
        @(posedge CLOCK); #1;
        drive_cycle(1'b1, 32'hAAAA0001, 4'b1111, 5'd7, 1'b0, 1'b0);
        drive_cycle(1'b1, 32'hAAAA0002, 4'b0101, 5'd8, 1'b0, 1'b0);
        // Mid-burst asynchronous reset, observed before any clock edge.
        IN_VALID = 1'b1;
        #2 RESET = 1'b1;
        #1;
        checks++;
        if (OUT_VALID !== 1'b0 || OUT_DATA !== 32'h0 || OUT_FLAGS !== 4'h0 || OUT_DEST !== 5'd0 ||
            COUNT !== 3'd0 || STICKY_FLAGS !== 4'h0 || STALL_CNT !== 16'h0 || IN_READY !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: got v=%b d=%h f=%b t=%0d c=%0d s=%b st=%0d r=%b expected all 0, ready 1",
                     OUT_VALID, OUT_DATA, OUT_FLAGS, OUT_DEST, COUNT, STICKY_FLAGS, STALL_CNT, IN_READY);
        end
        IN_VALID = 1'b0;
        @(posedge CLOCK); #1 RESET = 1'b0;
        model_clear();
        checks++;
        if (COUNT !== 3'd0 || OUT_VALID !== 1'b0) begin
            errors++;
            $display("FAIL reset_held: got count=%0d valid=%b expected 0/0", COUNT, OUT_VALID);
        end
    endtask

    task automatic test_fill();
        drive_cycle(1'b1, 32'h11111111, 4'b0000, 5'd1, 1'b0, 1'b0);
        checks++;
        if (OUT_VALID !== 1'b1 || OUT_DATA !== 32'h11111111) begin
            errors++;
            $display("FAIL push_latency: got v=%b d=%h expected 1/11111111", OUT_VALID, OUT_DATA);
        end
        drive_cycle(1'b1, 32'h22222222, 4'b0000, 5'd2, 1'b0, 1'b0);
        drive_cycle(1'b1, 32'h33333333, 4'b0000, 5'd3, 1'b0, 1'b0);
        drive_cycle(1'b1, 32'h44444444, 4'b0000, 5'd4, 1'b0, 1'b0);
        checks++;
        if (COUNT !== 3'd4 || IN_READY !== 1'b0) begin
            errors++;
            $display("FAIL fill: got count=%0d ready=%b expected 4/0", COUNT, IN_READY);
        end
    endtask

    task automatic test_back_pressure();
        for (int i = 0; i < 5; i++) drive_cycle(1'b1, 32'h55555555, 4'b0000, 5'd5, 1'b0, 1'b0);
        checks++;
        if (STALL_CNT !== 16'd5) begin
            errors++;
            $display("FAIL stall_cnt: got %0d expected 5", STALL_CNT);
        end
        IN_VALID = 1'b0; OUT_READY = 1'b1;
        #1;
        checks++;
        if (OUT_DATA !== 32'h11111111 || OUT_DEST !== 5'd1 || IN_READY !== 1'b0) begin
            errors++;
            $display("FAIL full_pop: got d=%h t=%0d ready=%b expected 11111111/1/0",
                     OUT_DATA, OUT_DEST, IN_READY);
        end
        drive_cycle(1'b0, 32'h0, 4'h0, 5'd0, 1'b1, 1'b0);
        checks++;
        if (IN_READY !== 1'b1 || COUNT !== 3'd3) begin
            errors++;
            $display("FAIL ready_after_pop: got ready=%b count=%0d expected 1/3", IN_READY, COUNT);
        end
    endtask

    task automatic test_streaming();
        logic [31:0] prev;
        while (m_count != 0) drive_cycle(1'b0, 32'h0, 4'h0, 5'd0, 1'b1, 1'b0);
        drive_cycle(1'b1, 32'h00001000, 4'b0000, 5'd0, 1'b0, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            prev = last_pushed;
            checks++;
            if (OUT_DATA !== prev) begin
                errors++;
                $display("FAIL stream_order: got %h expected %h", OUT_DATA, prev);
            end
            drive_cycle(1'b1, 32'h00001000 + 32'(i), 4'b0000, 5'(i), 1'b1, 1'b0);
            checks++;
            if (COUNT !== 3'd1) begin
                errors++;
                $display("FAIL stream_count: got %0d expected 1", COUNT);
            end
        end
        drive_cycle(1'b0, 32'h0, 4'h0, 5'd0, 1'b1, 1'b0);
    endtask

    task automatic test_sticky();
        drive_cycle(1'b0, 32'h0, 4'h0, 5'd0, 1'b0, 1'b1);
        checks++;
        if (STICKY_FLAGS !== 4'b0000) begin
            errors++;
            $display("FAIL sticky_clear: got %b expected 0000", STICKY_FLAGS);
        end
        drive_cycle(1'b1, 32'hC0DE0001, 4'b0010, 5'd9, 1'b0, 1'b0);
        drive_cycle(1'b1, 32'hC0DE0002, 4'b1000, 5'd10, 1'b0, 1'b0);
        checks++;
        if (STICKY_FLAGS !== 4'b1010 || STICKY_FLAGS !== m_sticky) begin
            errors++;
            $display("FAIL sticky_or: got %b expected 1010", STICKY_FLAGS);
        end
        drive_cycle(1'b1, 32'hC0DE0003, 4'b0001, 5'd11, 1'b0, 1'b1);
        checks++;
        if (STICKY_FLAGS !== 4'b0001) begin
            errors++;
            $display("FAIL sticky_clear_push: got %b expected 0001", STICKY_FLAGS);
        end
    endtask

    task automatic test_saturation_and_empty();
        while (m_count < DEPTH) drive_cycle(1'b1, 32'hF00D0000 + 32'(m_count), 4'b0100, 5'd20, 1'b0, 1'b0);
        for (int i = 0; i < 70000; i++) drive_cycle(1'b1, 32'hBEEF0000, 4'b0000, 5'd31, 1'b0, 1'b0);
        checks++;
        if (STALL_CNT !== 16'hFFFF || STALL_CNT !== m_stall) begin
            errors++;
            $display("FAIL stall_saturate: got %h expected ffff", STALL_CNT);
        end
        while (m_count != 0) drive_cycle(1'b0, 32'h0, 4'h0, 5'd0, 1'b1, 1'b0);
        checks++;
        if (OUT_VALID !== 1'b0 || OUT_DATA !== 32'h0 || OUT_FLAGS !== 4'h0 || OUT_DEST !== 5'd0) begin
            errors++;
            $display("FAIL drained: got v=%b d=%h f=%b t=%0d expected 0", OUT_VALID, OUT_DATA, OUT_FLAGS, OUT_DEST);
        end
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 32'h0, 4'h0, 5'd0, 1'b1, 1'b0);
        checks++;
        if (COUNT !== 3'd0 || STALL_CNT !== 16'hFFFF) begin
            errors++;
            $display("FAIL empty_pop: got count=%0d stall=%h expected 0/ffff", COUNT, STALL_CNT);
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left: got %0d entries expected 0", sb_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_back_pressure();
        test_streaming();
        test_sticky();
        test_saturation_and_empty();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_result_fifo.md
# alu_result_fifo

- Downstream stage of the 32-bit ALU.
- Captures each valid ALU result word (`Z`) with its 4-bit `FLAGS` and a 5-bit destination tag into a small in-order FIFO.
- Presents entries to writeback through a valid/ready handshake.
- Keeps sticky (accumulated) flags and a saturating back-pressure stall counter for debug and exception logic.

## Interface

Parameters:

- `DEPTH`, default 4: number of entries. Must be a power of two, ≥ 2.
- `WIDTH`, default 32: data width. Must match the ALU `Z` width.

Ports (clock and reset first):

- `CLOCK` in, 1: single clock; all state updates on the rising edge.
- `RESET` in, 1: asynchronous, active-high reset.
- `IN_VALID` in, 1: ALU result present this cycle.
- `IN_READY` out, 1: FIFO can accept an entry this cycle.
- `Z` in, WIDTH: ALU result.
- `FLAGS` in, 4: ALU flags; [3]=N, [2]=Z, [1]=C, [0]=V.
- `DEST` in, 5: destination register tag.
- `OUT_VALID` out, 1: head entry available.
- `OUT_READY` in, 1: writeback consumes the head this cycle.
- `OUT_DATA` out, WIDTH: head data.
- `OUT_FLAGS` out, 4: head flags.
- `OUT_DEST` out, 5: head tag.
- `COUNT` out, log2(DEPTH)+1: current occupancy.
- `STICKY_FLAGS` out, 4: OR of flags of all entries accepted since the last clear.
- `CLEAR_STICKY` in, 1: clear the sticky flags.
- `STALL_CNT` out, 16: count of cycles with `IN_VALID`=1 and `IN_READY`=0; saturates at 16'hFFFF.

## Operation

- Push = `IN_VALID` & `IN_READY`. Writes {`Z`, `FLAGS`, `DEST`} at the write pointer; write pointer increments.
- Pop = `OUT_VALID` & `OUT_READY`. Read pointer increments.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- `IN_READY` = (`COUNT` < DEPTH), taken from registered state only. When full, a simultaneous pop does not make `IN_READY` high in the same cycle (no combinational path `OUT_READY` -> `IN_READY`).
- `OUT_VALID` = (`COUNT` != 0).
- `OUT_DATA`/`OUT_FLAGS`/`OUT_DEST` are read combinationally from the head entry and forced to 0 when `OUT_VALID`=0.
- `COUNT` next value:
  - +1 on push only;
  - -1 on pop only;
  - unchanged on simultaneous push and pop (legal whenever 0 < `COUNT` < DEPTH).
- Empty: no fall-through. A push into an empty FIFO makes the entry visible the next cycle.
- Ordering is strictly FIFO. Entries are never dropped or reordered.
- `STICKY_FLAGS` next value:
  - `CLEAR_STICKY`=1 with no push: 0;
  - `CLEAR_STICKY`=1 with push: `FLAGS` of that push (clear applies first, then OR);
  - otherwise: `STICKY_FLAGS` | (push ? `FLAGS` : 0).
- `STALL_CNT` increments in every cycle with `IN_VALID`=1 and `IN_READY`=0, and holds at 16'hFFFF.
- Upstream must hold `Z`/`FLAGS`/`DEST` stable while `IN_VALID`=1 and `IN_READY`=0.

## Timing

- Reset values (take effect immediately on assertion of `RESET`, independent of `CLOCK`):
  - pointers = 0, `COUNT` = 0;
  - `OUT_VALID` = 0, `OUT_DATA`/`OUT_FLAGS`/`OUT_DEST` = 0;
  - `IN_READY` = 1;
  - `STICKY_FLAGS` = 0, `STALL_CNT` = 0.
- Storage array is not reset; its contents are masked by `OUT_VALID`.
- Reset asserted mid-operation discards all entries. The first edge after deassertion behaves as an empty FIFO.
- Latency from push to `OUT_VALID` is 1 cycle. Throughput is 1 entry/cycle with simultaneous push and pop.
- A pop in the cycle `COUNT` reaches DEPTH frees one slot; `IN_READY` rises on the following cycle.

## Test plan

- **Reset and fill.** Assert `RESET` mid-burst.
  - All outputs 0, `IN_READY`=1.
  - Push 0x11111111, 0x22222222, 0x33333333, 0x44444444 (DEST 1..4) with `OUT_READY`=0: `COUNT`=4, `IN_READY`=0.
- **Back-pressure.** With the FIFO full, hold `IN_VALID`=1 for 5 cycles.
  - `STALL_CNT`=5.
  - Pop once: `OUT_DATA`=0x11111111, `OUT_DEST`=1. Next cycle `IN_READY`=1.
- **Streaming.** Push and pop every cycle for 20 cycles of incrementing data.
  - `COUNT` constant at 1.
  - Output sequence equals input sequence delayed by 1 cycle.
  - Pointers wrap without error.
- **Sticky flags.**
  - Push `FLAGS`=4'b0010 then 4'b1000: `STICKY_FLAGS`=4'b1010.
  - `CLEAR_STICKY` together with a push of 4'b0001: `STICKY_FLAGS`=4'b0001.
- **Saturation and empty.**
  - Force 70000 stall cycles: `STALL_CNT`=16'hFFFF.
  - Drain the FIFO: `OUT_VALID`=0 and `OUT_DATA`=0.
  - Pop attempts while empty leave `COUNT` at 0.
